booth_seq_ctrl: RTL
===================

// Module: booth_seq_ctrl
// PURPOSE
//  Parametrised sequencing FSM for the radix-2 Booth multiplier datapath; it supersedes the fixed 8-bit controller.
//  - Drives Load / Operate / Shift strobes for any operand width.
//  - Decodes the Booth bit pair into an add/sub/none opcode.
//  - Start/Ready handshake, Abort, and an exposed iteration count.
//  - Sits between the top-level multiplier wrapper and the A/Q/M register datapath.
// PARAMETERS
//  WIDTH  8   operand width in bits = number of Booth iterations; legal range 2..32
//  CW     $clog2(WIDTH+1)  localparam, width of Count; not overridable
// PORTS
//  clk        in   1      rising-edge clock; single clock domain
//  Reset      in   1      synchronous, active-high; sampled on posedge clk
//  Start      in   1      request a multiply; honoured only in IDLE or DONE
//  Abort      in   1      synchronous cancel of an in-flight multiply
//  BoothBits  in   2      {Q[0], Q_-1} from datapath, valid in OPERATE
//  Ready      out  1      result valid; level, held in DONE
//  Busy       out  1      high in LOAD/OPERATE/SHIFT
//  Load       out  1      datapath load strobe, 1 cycle
//  Operate    out  1      datapath add/sub strobe
//  Op         out  2      2'b00 NONE, 2'b01 ADD M, 2'b10 SUB M; 2'b11 never driven
//  Shift      out  1      arithmetic-right-shift strobe for A:Q:Q_-1
//  Count      out  CW     completed shifts; 0..WIDTH
// BEHAVIOUR
//  - State register: IDLE, LOAD, OPERATE, SHIFT, DONE. All outputs are Moore decodes of the registered state plus Count.
//    Exception: Op also decodes BoothBits, and only during OPERATE.
//  - Reset: at the posedge with Reset=1, state<=IDLE and Count<=0.
//    All outputs are 0 in the following cycle. Reset overrides Start and Abort.
//  - IDLE: Start=1 -> LOAD.
//  - LOAD: Load=1; Count<=0 -> OPERATE.
//  - OPERATE: Operate=1; Op decode: 01->ADD, 10->SUB, 00/11->NONE (Operate still 1). Next state is SHIFT.
//  - SHIFT: Shift=1; Count<=Count+1.
//    If Count+1==WIDTH -> DONE, else -> OPERATE.
//  - DONE: Ready=1, Count held at WIDTH.
//    Start=1 -> LOAD and Ready drops the next cycle; otherwise stay in DONE.
//  - Latency: Start sampled at edge 0 -> LOAD in cycle 1, first OPERATE in cycle 2, last SHIFT in cycle 2*WIDTH+1.
//    Ready first high in cycle 2*WIDTH+2 (18 for WIDTH=8).
//  - Start in LOAD/OPERATE/SHIFT: ignored; no queuing.
//  - Abort=1 in LOAD/OPERATE/SHIFT -> IDLE next cycle; Count<=0; Ready stays 0.
//    Abort in IDLE/DONE: no effect.
//    Abort and Start together in DONE: Start wins.
//  - Count never wraps; it saturates at WIDTH in DONE. Its arithmetic is unsigned and CW bits wide.
//  - Mutual exclusion: at most one of Load/Operate/Shift is high in any cycle. Busy and Ready are never both high.
//  - No X/Z tolerance scheme: the reset is the only initialisation path. Outputs must be known from the first cycle after Reset.
// STRUCTURE
//  - Shared package booth_pkg:
//    - state encoding localparams ST_IDLE..ST_DONE
//    - Op encodings OP_NONE/OP_ADD/OP_SUB
//    - the function booth_decode(bits) -> op, shared with the future radix-4 controller
//  - One sub-module, booth_iter_counter:
//    - CW-bit counter with clr/inc/terminal-count (tc = Count+1==WIDTH).
//    - The FSM instantiates it and uses tc for the SHIFT->DONE transition.
// TESTING
//  - Reset mid-run: WIDTH=8; Start, then Reset in cycle 7 -> cycle 8 has all outputs 0, Count=0; the state stays IDLE until the next Start.
//  - Nominal: WIDTH=8; Start pulse at edge 0 -> Load in cycle 1; Operate/Shift alternate over cycles 2..17 (8 Shift pulses); Ready=1 from cycle 18 with Count=8.
//  - Decode: during OPERATE drive BoothBits 01/10/00/11 -> Op = 01/10/00/00 with Operate=1; Op=00 in every non-OPERATE cycle.
//  - Abort: Start, then Abort in cycle 6 (OPERATE) -> IDLE in cycle 7; Ready never rises; Count=0; a fresh Start then yields Ready 18 cycles later.
//  - Back-to-back and ignored Start:
//    - Start held high for cycles 0..10 -> only one LOAD.
//    - In DONE, Start -> Ready low the next cycle, and LOAD again.
//  - Parametric: WIDTH=2 -> Ready in cycle 6; WIDTH=16 -> Ready in cycle 34, Count=16. Assert strobe mutual exclusion every cycle in all runs.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared definitions for the Booth multiplier controllers: state codes, opcodes
// and the Booth bit-pair decoder.
package booth_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LOAD    = 3'd1;
  localparam logic [2:0] ST_OPERATE = 3'd2;
  localparam logic [2:0] ST_SHIFT   = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;

  // bits = {Q[0], Q_-1}: 01 ends a run of ones (add M), 10 starts one (subtract M)
  function automatic logic [1:0] booth_decode(input logic [1:0] bits);
    case (bits)
      2'b01:   return OP_ADD;
      2'b10:   return OP_SUB;
      default: return OP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/booth_iter_counter.sv
// Iteration counter for the Booth sequencer: clear, increment, saturate at WIDTH,
// and flag the last iteration (count + 1 == WIDTH).
module booth_iter_counter #(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned CW    = $clog2(WIDTH + 1)
) (
  input  logic          clk,
  input  logic          Reset,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          tc
);

  localparam logic [CW-1:0] FULL = CW'(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  always_ff @(posedge clk) begin
    if (Reset || clr)
      count <= '0;
    else if (inc && (count != FULL))
      count <= count + CW'(1);
  end

  assign tc = (count == LAST);

endmodule

// File: rtl/booth_seq_ctrl.sv
// Sequencing FSM for the radix-2 Booth multiplier datapath: Load, then WIDTH
// Operate/Shift pairs, then Ready held until the next Start.
module booth_seq_ctrl
  import booth_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned CW    = $clog2(WIDTH + 1)
) (
  input  logic          clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic          Abort,
  input  logic [1:0]    BoothBits,
  output logic          Ready,
  output logic          Busy,
  output logic          Load,
  output logic          Operate,
  output logic [1:0]    Op,
  output logic          Shift,
  output logic [CW-1:0] Count
);

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic       tc;
  logic       cnt_clr;
  logic       cnt_inc;

  always_ff @(posedge clk) begin
    if (Reset)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (Start) state_nxt = ST_LOAD;
      ST_LOAD:    state_nxt = Abort ? ST_IDLE : ST_OPERATE;
      ST_OPERATE: state_nxt = Abort ? ST_IDLE : ST_SHIFT;
      ST_SHIFT:   state_nxt = Abort ? ST_IDLE : (tc ? ST_DONE : ST_OPERATE);
      ST_DONE:    if (Start) state_nxt = ST_LOAD;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  assign Busy    = (state == ST_LOAD) || (state == ST_OPERATE) || (state == ST_SHIFT);
  assign Ready   = (state == ST_DONE);
  assign Load    = (state == ST_LOAD);
  assign Operate = (state == ST_OPERATE);
  assign Shift   = (state == ST_SHIFT);
  assign Op      = Operate ? booth_decode(BoothBits) : OP_NONE;

  // Abort clears the count together with the return to IDLE
  assign cnt_clr = Load || (Busy && Abort);
  assign cnt_inc = Shift && !Abort;

  booth_iter_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk   (clk),
    .Reset (Reset),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .count (Count),
    .tc    (tc)
  );

endmodule
